// File: rtl/wb_arbiter.sv
// ============================================================================
// Module   : wb_arbiter
// Brief    : Two-source register-file write-back arbiter (ALU port A, load
//            port B) with round-robin tie-break and a registered write port.
//            Optional per-register pending-write scoreboard, compiled only
//            when WB_ARBITER_SCOREBOARD_EN is defined; otherwise busy is 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [ADDR_W-1:0]    a_addr,
  input  logic [DATA_W-1:0]    a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [ADDR_W-1:0]    b_addr,
  input  logic [DATA_W-1:0]    b_data,
  input  logic                 rsv_valid,
  input  logic [ADDR_W-1:0]    rsv_addr,
  output logic                 write,
  output logic [ADDR_W-1:0]    write_address,
  output logic [DATA_W-1:0]    write_data,
  output logic [2**ADDR_W-1:0] busy,
  output logic                 last_b
);

  localparam int NREG = 2**ADDR_W;

  logic              write_q, write_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              last_b_q, last_b_d;
  logic              grant_a, grant_b;

  // Ready depends only on the other source's valid and the last winner, so
  // a lone requester is always accepted and a tie goes to the one not last served.
  always_comb begin
    a_ready = !reset && (!b_valid || last_b_q);
    b_ready = !reset && (!a_valid || !last_b_q);
    grant_a = a_valid && a_ready;
    grant_b = b_valid && b_ready;
  end

  // Next write-port state: strobe follows any acceptance, address/data hold otherwise.
  always_comb begin
    write_d  = grant_a || grant_b;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    last_b_d = last_b_q;
    if (grant_a) begin
      waddr_d  = a_addr;
      wdata_d  = a_data;
      last_b_d = 1'b0;
    end else if (grant_b) begin
      waddr_d  = b_addr;
      wdata_d  = b_data;
      last_b_d = 1'b1;
    end
  end

  // Write-port and round-robin registers; last_b resets to 1 so A wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q  <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      last_b_q <= 1'b1;
    end else begin
      write_q  <= write_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      last_b_q <= last_b_d;
    end
  end

  assign write         = write_q;
  assign write_address = waddr_q;
  assign write_data    = wdata_q;
  assign last_b        = last_b_q;

`ifdef WB_ARBITER_SCOREBOARD_EN
  logic [NREG-1:0] busy_q, busy_d;

  // Clear on the issued write, then set on reservation so a same-edge reserve wins.
  always_comb begin
    busy_d = busy_q;
    if (write_q) begin
      busy_d[waddr_q] = 1'b0;
    end
    if (rsv_valid) begin
      busy_d[rsv_addr] = 1'b1;
    end
  end

  // Pending-write flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
`else
  logic unused_rsv;

  assign unused_rsv = ^{rsv_valid, rsv_addr};
  assign busy       = {NREG{1'b0}};
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ============================================================================
// Module   : tb_wb_arbiter
// Brief    : Self-checking bench for wb_arbiter: directed scenarios plus a
//            randomized run against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_arbiter;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREG   = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              a_valid, b_valid, a_ready, b_ready;
  logic [ADDR_W-1:0] a_addr, b_addr, rsv_addr, write_address;
  logic [DATA_W-1:0] a_data, b_data, write_data;
  logic              rsv_valid, write, last_b;
  logic [NREG-1:0]   busy;

  int tests_run    = 0;
  int tests_failed = 0;

  wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .write(write), .write_address(write_address), .write_data(write_data),
    .busy(busy), .last_b(last_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running want finished");
    $fatal(1, "timeout");
  end

  task automatic idle_inputs();
    a_valid = 1'b0; b_valid = 1'b0; rsv_valid = 1'b0;
    a_addr = '0; b_addr = '0; rsv_addr = '0; a_data = '0; b_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    a_valid = 1'b1; b_valid = 1'b1;
    @(negedge clk);
    tests_run++; if (write !== 1'b0) begin tests_failed++; $display("FAIL reset_write: got %b want 0", write); end
    tests_run++; if (write_address !== 3'd0) begin tests_failed++; $display("FAIL reset_waddr: got %0d want 0", write_address); end
    tests_run++; if (write_data !== 16'h0) begin tests_failed++; $display("FAIL reset_wdata: got %h want 0000", write_data); end
    tests_run++; if (busy !== 8'h00) begin tests_failed++; $display("FAIL reset_busy: got %h want 00", busy); end
    tests_run++; if (last_b !== 1'b1) begin tests_failed++; $display("FAIL reset_last_b: got %b want 1", last_b); end
    tests_run++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b%b want 00", a_ready, b_ready); end
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_a_only();
    @(negedge clk);
    a_valid = 1'b1; a_addr = 3'd3; a_data = 16'h1234; b_valid = 1'b0;
    #1;
    tests_run++; if (a_ready !== 1'b1) begin tests_failed++; $display("FAIL aonly_ready: got %b want 1", a_ready); end
    @(negedge clk);
    a_valid = 1'b0;
    tests_run++; if (write !== 1'b1) begin tests_failed++; $display("FAIL aonly_write: got %b want 1", write); end
    tests_run++; if (write_address !== 3'd3) begin tests_failed++; $display("FAIL aonly_waddr: got %0d want 3", write_address); end
    tests_run++; if (write_data !== 16'h1234) begin tests_failed++; $display("FAIL aonly_wdata: got %h want 1234", write_data); end
    @(negedge clk);
    tests_run++; if (write !== 1'b0) begin tests_failed++; $display("FAIL aonly_write_drop: got %b want 0", write); end
    tests_run++; if (write_address !== 3'd3 || write_data !== 16'h1234) begin tests_failed++; $display("FAIL aonly_hold: got %0d/%h want 3/1234", write_address, write_data); end
  endtask

  task automatic test_round_robin();
    int ka, kb;
    logic exp_a;
    do_reset();
    repeat (3) @(negedge clk);
    ka = 0; kb = 0;
    a_valid = 1'b1; a_addr = 3'd1; a_data = 16'hA000;
    b_valid = 1'b1; b_addr = 3'd2; b_data = 16'hB000;
    for (int i = 0; i < 4; i++) begin
      exp_a = (i % 2 == 0);
      #1;
      tests_run++; if (a_ready !== exp_a || b_ready !== !exp_a) begin tests_failed++; $display("FAIL rr_ready%0d: got %b%b want %b%b", i, a_ready, b_ready, exp_a, !exp_a); end
      @(negedge clk);
      tests_run++; if (write !== 1'b1) begin tests_failed++; $display("FAIL rr_write%0d: got %b want 1", i, write); end
      tests_run++; if (write_address !== (exp_a ? 3'd1 : 3'd2)) begin tests_failed++; $display("FAIL rr_waddr%0d: got %0d want %0d", i, write_address, exp_a ? 1 : 2); end
      if (exp_a) begin
        tests_run++; if (write_data !== 16'hA000 + 16'(ka)) begin tests_failed++; $display("FAIL rr_wdata%0d: got %h want %h", i, write_data, 16'hA000 + 16'(ka)); end
        ka++; a_data = 16'hA000 + 16'(ka);
      end else begin
        tests_run++; if (write_data !== 16'hB000 + 16'(kb)) begin tests_failed++; $display("FAIL rr_wdata%0d: got %h want %h", i, write_data, 16'hB000 + 16'(kb)); end
        kb++; b_data = 16'hB000 + 16'(kb);
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (write !== 1'b0) begin tests_failed++; $display("FAIL rr_write_end: got %b want 0", write); end
  endtask

  task automatic test_same_addr();
    @(negedge clk);
    a_valid = 1'b1; a_addr = 3'd0; a_data = 16'h0001; b_valid = 1'b0;
    @(negedge clk);
    a_addr = 3'd5; a_data = 16'h00AA;
    b_valid = 1'b1; b_addr = 3'd5; b_data = 16'h00BB;
    #1;
    tests_run++; if (a_ready !== 1'b0 || b_ready !== 1'b1) begin tests_failed++; $display("FAIL same_ready1: got %b%b want 01", a_ready, b_ready); end
    @(negedge clk);
    tests_run++; if (write !== 1'b1 || write_address !== 3'd5 || write_data !== 16'h00BB) begin tests_failed++; $display("FAIL same_first: got %b/%0d/%h want 1/5/00bb", write, write_address, write_data); end
    b_valid = 1'b0;
    #1;
    tests_run++; if (a_ready !== 1'b1) begin tests_failed++; $display("FAIL same_ready2: got %b want 1", a_ready); end
    @(negedge clk);
    a_valid = 1'b0;
    tests_run++; if (write !== 1'b1 || write_address !== 3'd5 || write_data !== 16'h00AA) begin tests_failed++; $display("FAIL same_second: got %b/%0d/%h want 1/5/00aa", write, write_address, write_data); end
    tests_run++; if (last_b !== 1'b0) begin tests_failed++; $display("FAIL same_last_b: got %b want 0", last_b); end
    @(negedge clk);
    tests_run++; if (write !== 1'b0) begin tests_failed++; $display("FAIL same_write_end: got %b want 0", write); end
  endtask

  task automatic test_scoreboard();
`ifdef WB_ARBITER_SCOREBOARD_EN
    @(negedge clk);
    rsv_valid = 1'b1; rsv_addr = 3'd6;
    @(negedge clk);
    rsv_valid = 1'b0;
    tests_run++; if (busy !== 8'h40) begin tests_failed++; $display("FAIL sb_set: got %h want 40", busy); end
    a_valid = 1'b1; a_addr = 3'd6; a_data = 16'h0606;
    @(negedge clk);
    a_valid = 1'b0;
    tests_run++; if (write !== 1'b1 || busy !== 8'h40) begin tests_failed++; $display("FAIL sb_strobe: got %b/%h want 1/40", write, busy); end
    @(negedge clk);
    tests_run++; if (busy !== 8'h00) begin tests_failed++; $display("FAIL sb_clear: got %h want 00", busy); end
    a_valid = 1'b1; a_addr = 3'd6;
    @(negedge clk);
    a_valid = 1'b0;
    rsv_valid = 1'b1; rsv_addr = 3'd6;
    tests_run++; if (write !== 1'b1 || write_address !== 3'd6) begin tests_failed++; $display("FAIL sb_strobe2: got %b/%0d want 1/6", write, write_address); end
    @(negedge clk);
    rsv_valid = 1'b0;
    tests_run++; if (busy !== 8'h40) begin tests_failed++; $display("FAIL sb_collide: got %h want 40", busy); end
    a_valid = 1'b1; a_addr = 3'd6;
    @(negedge clk);
    a_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (busy !== 8'h00) begin tests_failed++; $display("FAIL sb_cleanup: got %h want 00", busy); end
`else
    for (int i = 0; i < NREG; i++) begin
      @(negedge clk);
      tests_run++; if (busy !== 8'h00) begin tests_failed++; $display("FAIL sb_off%0d: got %h want 00", i, busy); end
      rsv_valid = 1'b1; rsv_addr = 3'(i);
    end
    @(negedge clk);
    rsv_valid = 1'b0;
    tests_run++; if (busy !== 8'h00) begin tests_failed++; $display("FAIL sb_off_end: got %h want 00", busy); end
`endif
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a_valid = 1'b1; a_addr = 3'd4; a_data = 16'hDEAD; b_valid = 1'b0;
    rsv_valid = 1'b1; rsv_addr = 3'd2;
    @(posedge clk);
    #1;
    reset = 1'b1;
    a_valid = 1'b0; rsv_valid = 1'b0;
    #1;
    tests_run++; if (write !== 1'b0) begin tests_failed++; $display("FAIL rmid_write: got %b want 0", write); end
    tests_run++; if (busy !== 8'h00) begin tests_failed++; $display("FAIL rmid_busy: got %h want 00", busy); end
    tests_run++; if (last_b !== 1'b1) begin tests_failed++; $display("FAIL rmid_last_b: got %b want 1", last_b); end
    tests_run++; if (write_address !== 3'd0 || write_data !== 16'h0) begin tests_failed++; $display("FAIL rmid_wport: got %0d/%h want 0/0000", write_address, write_data); end
    a_valid = 1'b1;
    #1;
    tests_run++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin tests_failed++; $display("FAIL rmid_ready: got %b%b want 00", a_ready, b_ready); end
    a_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (write !== 1'b0) begin tests_failed++; $display("FAIL rmid_write2: got %b want 0", write); end
    reset = 1'b0;
    @(negedge clk);
    tests_run++; if (write !== 1'b0 || last_b !== 1'b1) begin tests_failed++; $display("FAIL rmid_after: got %b/%b want 0/1", write, last_b); end
  endtask

  // Transaction-level model: pick a winner per cycle from the arbitration
  // rules, then expect that winner's address/data on the write port next cycle.
  task automatic test_random();
    bit              m_last_b, m_write, win_a, win_b, a_taken, b_taken, exp_ar, exp_br;
    logic [2:0]      m_waddr;
    logic [15:0]     m_wdata;
    logic [NREG-1:0] m_busy, nb;
    logic [31:0]     r;
    do_reset();
    m_last_b = 1'b1; m_write = 1'b0; m_waddr = '0; m_wdata = '0; m_busy = '0;
    a_taken = 1'b1; b_taken = 1'b1;
    for (int cyc = 0; cyc < 500; cyc++) begin
      tests_run++; if (write !== m_write) begin tests_failed++; $display("FAIL rnd_write c%0d: got %b want %b", cyc, write, m_write); end
      tests_run++; if (write_address !== m_waddr || write_data !== m_wdata) begin tests_failed++; $display("FAIL rnd_wport c%0d: got %0d/%h want %0d/%h", cyc, write_address, write_data, m_waddr, m_wdata); end
      tests_run++; if (busy !== m_busy) begin tests_failed++; $display("FAIL rnd_busy c%0d: got %h want %h", cyc, busy, m_busy); end
      tests_run++; if (last_b !== m_last_b) begin tests_failed++; $display("FAIL rnd_last_b c%0d: got %b want %b", cyc, last_b, m_last_b); end
      if (!a_valid || a_taken) begin
        r = $urandom; a_valid = (r[1:0] != 2'b00); a_addr = r[4:2]; a_data = r[31:16];
      end
      if (!b_valid || b_taken) begin
        r = $urandom; b_valid = (r[1:0] != 2'b00); b_addr = r[4:2]; b_data = r[31:16];
      end
      r = $urandom; rsv_valid = (r[1:0] == 2'b00); rsv_addr = r[4:2];
      #1;
      if (a_valid && b_valid) begin
        win_a = m_last_b; win_b = !m_last_b;
      end else begin
        win_a = a_valid; win_b = b_valid;
      end
      exp_ar = !b_valid || m_last_b;
      exp_br = !a_valid || !m_last_b;
      tests_run++; if (a_ready !== exp_ar || b_ready !== exp_br) begin tests_failed++; $display("FAIL rnd_ready c%0d: got %b%b want %b%b", cyc, a_ready, b_ready, exp_ar, exp_br); end
      nb = m_busy;
`ifdef WB_ARBITER_SCOREBOARD_EN
      if (m_write) nb[m_waddr] = 1'b0;
      if (rsv_valid) nb[rsv_addr] = 1'b1;
`endif
      m_busy  = nb;
      m_write = win_a || win_b;
      if (win_a) begin m_waddr = a_addr; m_wdata = a_data; m_last_b = 1'b0; end
      if (win_b) begin m_waddr = b_addr; m_wdata = b_data; m_last_b = 1'b1; end
      a_taken = win_a; b_taken = win_b;
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_round_robin();
    test_same_addr();
    test_scoreboard();
    test_reset_mid();
    test_random();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
